// File: rtl/pingpong_buf.sv
// Multi-bank staging buffer with explicit writer-commit / engine-release
// bank ownership between a write port and a registered read port.
module pingpong_buf #(
   parameter  int DW    = 16,
   parameter  int DEPTH = 4096,
   parameter  int NBANK = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int BW    = $clog2(NBANK)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_v,
   input  logic [AW-1:0] wr_a,
   input  logic [DW-1:0] wr_d,
   input  logic          wr_last,
   output logic          wr_rdy,
   output logic [BW-1:0] wr_bank,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_a,
   output logic [DW-1:0] rd_d,
   output logic          rd_valid,
   output logic          rd_rdy,
   input  logic          rd_done,
   output logic [BW-1:0] rd_bank,
   output logic [BW:0]   full_cnt,
   output logic          err
);

   localparam int          MW   = NBANK * (2 ** AW);
   localparam logic [BW:0] FULL = (BW + 1)'(NBANK);

   logic [DW-1:0] mem [MW];
   logic [BW-1:0] wp;
   logic [BW-1:0] rp;
   logic [BW:0]   cnt;
   logic          wa_ok;
   logic          ra_ok;
   logic          wr_acc;
   logic          rd_acc;
   logic          commit;
   logic          rel;
   logic          bad;

   // Address range checks only exist when DEPTH leaves unused codes.
   generate
      if ((2 ** AW) == DEPTH) begin : g_pow2
         assign wa_ok = 1'b1;
         assign ra_ok = 1'b1;
      end else begin : g_npow2
         assign wa_ok = (wr_a < AW'(DEPTH));
         assign ra_ok = (rd_a < AW'(DEPTH));
      end
   endgenerate

   assign wr_rdy   = (cnt != FULL);
   assign rd_rdy   = (cnt != '0);
   assign wr_bank  = wp;
   assign rd_bank  = rp;
   assign full_cnt = cnt;

   assign wr_acc = wr_v & wr_rdy & wa_ok;
   assign commit = wr_acc & wr_last;
   assign rd_acc = rd_en & rd_rdy & ra_ok;
   assign rel    = rd_done & rd_rdy;

   assign bad = (wr_v & ~(wr_rdy & wa_ok))
              | ((rd_en | rd_done) & ~rd_rdy)
              | (rd_en & ~ra_ok);

   always_ff @(posedge clk) begin
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (commit) wp <= wp + 1'b1;
         if (rel) rp <= rp + 1'b1;
         cnt <= cnt + {{BW{1'b0}}, commit} - {{BW{1'b0}}, rel};
         if (bad) err <= 1'b1;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[{wp, wr_a}] <= wr_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_d     <= '0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) rd_d <= mem[{rp, rd_a}];
      end
   end

endmodule
